// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants for the ALU decode path and its encoder.
package riscv_pkg;

  // ALUControl codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Major opcodes
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  // funct3 / funct7 fields
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [6:0] F7_SUB     = 7'b0100000;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // One buffered instruction: encoded word plus end-of-program marker
  typedef struct packed {
    logic        last;
    logic [31:0] insn;
  } enc_entry_t;

  localparam int unsigned ENTRY_W = $bits(enc_entry_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } enc_state_t;

endpackage

// File: rtl/alu_instr_encoder_if.sv
// Request bus and instruction-memory write port of the ALU instruction encoder.
//   master: request source / memory side (testbench, loader)
//   slave : the encoder
interface alu_instr_encoder_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_alu_ctrl;
  logic              req_imm_sel;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [11:0]       req_imm;
  logic              req_last;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output req_valid, req_alu_ctrl, req_imm_sel, req_rd, req_rs1, req_rs2,
           req_imm, req_last, imem_ready,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  req_valid, req_alu_ctrl, req_imm_sel, req_rd, req_rs1, req_rs2,
           req_imm, req_last, imem_ready,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/alu_instr_encoder_enc_fifo.sv
// Synchronous FIFO for encoded entries.
//   clear : drop all contents (wins over push/pop)
//   push/pop : ignored when full/empty respectively
//   rdata : head entry, read from the storage flops
//   full, empty, count : occupancy flags
module enc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] rptr_q, rptr_d;

  // Pointers carry one extra wrap bit to tell full from empty
  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (count == CNT_W'(DEPTH));
  assign rdata = mem_q[rptr_q[PTR_W-1:0]];

  // Next-state for storage and pointers
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wptr_q[PTR_W-1:0]] = wdata;
        wptr_d = wptr_q + CNT_W'(1);
      end
      if (pop && !empty) begin
        rptr_d = rptr_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
endmodule

// File: rtl/alu_instr_encoder.sv
// Encodes ALU operation requests into RV32I R/I-type words, buffers them and
// streams them into instruction memory at incrementing word addresses.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous restart (FIFO, address, done, err)
//   bus        : request handshake in, imem write port out
//   busy       : FIFO non-empty
//   done       : sticky, program finished or memory filled
//   err        : sticky, an illegal request was replaced by a NOP
module alu_instr_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  alu_instr_encoder_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  enc_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  enc_entry_t        push_entry, head;
  logic              illegal;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic              push, commit, term;

  // Request -> instruction word
  always_comb begin
    illegal = 1'b0;
    funct3  = F3_ADD_SUB;
    funct7  = F7_ZERO;
    case (bus.req_alu_ctrl)
      ALU_ADD: funct3 = F3_ADD_SUB;
      ALU_SUB: begin
        funct3  = F3_ADD_SUB;
        funct7  = F7_SUB;
        illegal = bus.req_imm_sel;  // no subi in RV32I
      end
      ALU_SLT: funct3 = F3_SLT;
      ALU_OR:  funct3 = F3_OR;
      ALU_AND: funct3 = F3_AND;
      default: illegal = 1'b1;
    endcase

    push_entry.last = bus.req_last;
    if (illegal) begin
      push_entry.insn = NOP_INSN;
    end else if (bus.req_imm_sel) begin
      push_entry.insn = {bus.req_imm, bus.req_rs1, funct3, bus.req_rd, OP_ITYPE};
    end else begin
      push_entry.insn = {funct7, bus.req_rs2, bus.req_rs1, funct3, bus.req_rd, OP_RTYPE};
    end
  end

  assign done           = (state_q == ST_DONE);
  assign err            = err_q;
  assign busy           = !fifo_empty;
  assign bus.req_ready  = !fifo_full && !done;
  assign bus.imem_we    = !fifo_empty && !done;
  assign bus.imem_addr  = addr_q;
  // Idle data bus reads as zero rather than a stale slot
  assign bus.imem_wdata = fifo_empty ? 32'h0 : head.insn;

  assign push   = bus.req_valid && bus.req_ready;
  assign commit = bus.imem_we && bus.imem_ready;
  assign term   = commit && (head.last || (addr_q == ADDR_MAX));

  // Leftover entries are discarded when the program terminates
  enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear || term),
    .push  (push),
    .wdata (push_entry),
    .pop   (commit),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sequencer next-state; clear overrides everything
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    if (clear) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      err_d   = 1'b0;
    end else begin
      if (commit && (addr_q != ADDR_MAX)) addr_d = addr_q + ADDR_W'(1);
      if (push && illegal) err_d = 1'b1;
      case (state_q)
        ST_IDLE:  if (push) state_d = ST_WRITE;
        ST_WRITE: begin
          if (term) begin
            state_d = ST_DONE;
          end else if (commit && !push && (fifo_count == CNT_W'(1))) begin
            state_d = ST_IDLE;
          end
        end
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_instr_encoder.sv
// Self-checking bench for alu_instr_encoder: directed cases plus random traffic
// against a queue-based reference model.
module tb_alu_instr_encoder;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 4;
  localparam int          MAXA   = (1 << ADDR_W) - 1;

  localparam logic [2:0] C_ADD = 3'd0, C_SUB = 3'd1, C_AND = 3'd2,
                         C_OR  = 3'd3, C_SLT = 3'd5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic busy, done, err;

  alu_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  alu_instr_encoder #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [32:0] m_q [$];
  int          m_addr = 0;
  bit          m_done = 0;
  bit          m_err  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_bad(input logic [2:0] c, input bit isel);
    return (c == 3'd4) || (c == 3'd6) || (c == 3'd7) || (c == C_SUB && isel);
  endfunction

  // {last, word} from the ISA field layout
  function automatic logic [32:0] ref_word(input logic [2:0] c, input bit isel,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [11:0] imm, input bit last);
    logic [31:0] f3, f7, w;
    f7 = 0;
    case (c)
      C_SUB:   begin f3 = 0; f7 = 32; end
      C_SLT:   f3 = 2;
      C_OR:    f3 = 6;
      C_AND:   f3 = 7;
      default: f3 = 0;
    endcase
    if (ref_bad(c, isel))
      w = 32'h13;
    else if (isel)
      w = 32'(imm) * 32'h10_0000 + 32'(rs1) * 32'h8000 + f3 * 32'h1000 + 32'(rd) * 32'h80 + 32'h13;
    else
      w = f7 * 32'h200_0000 + 32'(rs2) * 32'h10_0000 + 32'(rs1) * 32'h8000 + f3 * 32'h1000
          + 32'(rd) * 32'h80 + 32'h33;
    return {last, w};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_addr = 0;
    m_done = 0;
    m_err  = 0;
  endtask

  task automatic check_all();
    bit exp_ready, exp_we;
    exp_ready = (m_q.size() < DEPTH) && !m_done;
    exp_we    = (m_q.size() > 0) && !m_done;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("imem_we",   32'(bus.imem_we),   32'(exp_we));
    check("imem_addr", 32'(bus.imem_addr), 32'(m_addr));
    check("busy",      32'(busy),          32'(m_q.size() > 0));
    check("done",      32'(done),          32'(m_done));
    check("err",       32'(err),           32'(m_err));
    if (exp_we) check("imem_wdata", bus.imem_wdata, m_q[0][31:0]);
  endtask

  // Drive one cycle at a negedge, advance the model, check at the next negedge
  task automatic step(input bit v, input logic [2:0] c, input bit isel,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [11:0] imm, input bit last, input bit rdy, input bit clr);
    bit          acc, com, term;
    logic [32:0] h;
    bus.req_valid    = v;
    bus.req_alu_ctrl = c;
    bus.req_imm_sel  = isel;
    bus.req_rd       = rd;
    bus.req_rs1      = rs1;
    bus.req_rs2      = rs2;
    bus.req_imm      = imm;
    bus.req_last     = last;
    bus.imem_ready   = rdy;
    clear            = clr;
    if (clr) begin
      model_reset();
    end else begin
      acc  = v && (m_q.size() < DEPTH) && !m_done;
      com  = rdy && (m_q.size() > 0) && !m_done;
      term = 0;
      if (com) begin
        h    = m_q.pop_front();
        term = h[32] || (m_addr == MAXA);
        if (m_addr != MAXA) m_addr++;
      end
      if (acc && ref_bad(c, isel)) m_err = 1;
      if (term) begin
        m_done = 1;
        m_q.delete();
      end else if (acc) begin
        m_q.push_back(ref_word(c, isel, rd, rs1, rs2, imm, last));
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input bit rdy);
    step(0, C_ADD, 0, 0, 0, 0, 0, 0, rdy, 0);
  endtask

  task automatic do_clear();
    step(0, C_ADD, 0, 0, 0, 0, 0, 0, 0, 1);
    clear = 1'b0;
  endtask

  initial begin
    bus.req_valid = 0; bus.req_alu_ctrl = 0; bus.req_imm_sel = 0;
    bus.req_rd = 0; bus.req_rs1 = 0; bus.req_rs2 = 0; bus.req_imm = 0;
    bus.req_last = 0; bus.imem_ready = 0;

    // reset values
    #3;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_imem_we",   32'(bus.imem_we),   32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_imem_wdata", bus.imem_wdata,    32'd0);
    check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // single add, written one cycle after acceptance
    step(1, C_ADD, 0, 1, 2, 3, 0, 0, 1, 0);
    check("add_word", bus.imem_wdata, 32'h003100B3);
    check("add_addr", 32'(bus.imem_addr), 32'd0);
    idle(1);

    // sub R then and I back-to-back
    do_clear();
    step(1, C_SUB, 0, 5, 6, 7, 0, 0, 1, 0);
    check("sub_word", bus.imem_wdata, 32'h407302B3);
    step(1, C_AND, 1, 1, 1, 0, 12'hFFF, 0, 1, 0);
    check("andi_word", bus.imem_wdata, 32'hFFF0F093);
    check("andi_addr", 32'(bus.imem_addr), 32'd1);
    idle(1);

    // illegal requests become NOP and set err until clear
    step(1, C_SUB, 1, 3, 4, 0, 12'h123, 0, 0, 0);
    check("subi_nop", bus.imem_wdata, 32'h00000013);
    check("subi_err", 32'(err), 32'd1);
    step(1, 3'd6, 0, 3, 4, 5, 0, 0, 1, 0);
    idle(1);
    idle(1);
    check("err_sticky", 32'(err), 32'd1);
    do_clear();
    check("err_cleared", 32'(err), 32'd0);

    // back-pressure: 5 offered, 4 accepted, stable until memory ready
    for (int i = 0; i < 5; i++) step(1, C_ADD, 0, 1, 2, 3, 0, 0, 0, 0);
    check("bp_ready_low", 32'(bus.req_ready), 32'd0);
    check("bp_addr_hold", 32'(bus.imem_addr), 32'd0);
    check("bp_data_hold", bus.imem_wdata, 32'h003100B3);
    idle(1);
    check("bp_ready_back", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) idle(1);
    check("bp_addr_end", 32'(bus.imem_addr), 32'd4);

    // fill the whole memory
    do_clear();
    for (int i = 0; i < MAXA + 4; i++) step(1, C_OR, 1, 5'(i), 5'(i + 1), 0, 12'(i), 0, 1, 0);
    check("fill_done", 32'(done), 32'd1);
    check("fill_ready", 32'(bus.req_ready), 32'd0);
    check("fill_we", 32'(bus.imem_we), 32'd0);

    // last on the second request
    do_clear();
    step(1, C_SLT, 0, 1, 2, 3, 0, 0, 1, 0);
    step(1, C_SLT, 0, 4, 5, 6, 0, 1, 1, 0);
    check("last_not_done", 32'(done), 32'd0);
    step(1, C_ADD, 0, 7, 8, 9, 0, 0, 1, 0);
    check("last_done", 32'(done), 32'd1);
    idle(1);

    // asynchronous reset mid-burst
    do_clear();
    for (int i = 0; i < 3; i++) step(1, C_ADD, 0, 5'(i), 2, 3, 0, 0, 0, 0);
    step(1, C_ADD, 0, 9, 2, 3, 0, 0, 1, 0);
    bus.req_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_we", 32'(bus.imem_we), 32'd0);
    check("arst_addr", 32'(bus.imem_addr), 32'd0);
    check("arst_wdata", bus.imem_wdata, 32'd0);
    check("arst_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    step(1, C_ADD, 0, 1, 2, 3, 0, 0, 1, 0);
    check("arst_next_addr", 32'(bus.imem_addr), 32'd0);
    idle(1);

    // synchronous clear beats a simultaneous push
    for (int i = 0; i < 3; i++) step(1, C_OR, 0, 5'(i), 2, 3, 0, 0, 0, 0);
    step(1, C_ADD, 0, 1, 2, 3, 0, 0, 1, 1);
    clear = 1'b0;
    check("clr_busy", 32'(busy), 32'd0);
    step(1, C_ADD, 0, 1, 2, 3, 0, 0, 1, 0);
    check("clr_next_addr", 32'(bus.imem_addr), 32'd0);
    check("clr_next_word", bus.imem_wdata, 32'h003100B3);

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      bit clr;
      clr = ($urandom_range(0, 199) == 0) || (m_done && ($urandom_range(0, 3) == 0));
      step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom),
           $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 6, clr);
    end
    clear = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_instr_encoder.md
# alu_instr_encoder

Inverse of the ALU decode path. Accepts ALU operation requests expressed as an ALUControl code plus register/immediate fields, and encodes them into RV32I R-type or I-type instruction words. It buffers them in a small FIFO and streams them into instruction memory over a valid/ready write port at incrementing word addresses. Sits in front of the instruction memory as the program-loader/self-test source for the single-cycle core.

## Interface
- ADDR_W, 6: instruction-memory word-address width; capacity is 2^ADDR_W words.
- FIFO_DEPTH, 4: request buffer depth; must be a power of two and at least 2.

- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart: empties the FIFO and zeroes the address, done and err.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a clock edge.
- req_alu_ctrl  in  3  000 add, 001 sub, 101 slt, 011 or, 010 and; other codes are illegal.
- req_imm_sel  in  1  0 = R-type (uses rs2), 1 = I-type (uses imm).
- req_rd, req_rs1, req_rs2  in  5 each  register indices.
- req_imm  in  12  I-type immediate.
- req_last  in  1  marks the final instruction of the program.
- imem_we  out  1  write request to instruction memory.
- imem_ready  in  1  memory accepts the write; a write commits when imem_we && imem_ready.
- imem_addr  out  ADDR_W  word address of the current write.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  FIFO non-empty.
- done  out  1  sticky: program complete or memory filled.
- err  out  1  sticky: at least one illegal request was encoded as NOP.

## Operation
- Encoding is applied at FIFO push. The FIFO stores the 32-bit word plus the last flag.
- R-type: op 0110011; funct7 is 0100000 for sub and 0000000 otherwise. The word is {funct7, rs2, rs1, funct3, rd, op}.
- I-type: op 0010011. The word is {imm[11:0], rs1, funct3, rd, op}.
- funct3 mapping: add/sub 000, slt 010, or 110, and 111.
- Illegal requests are accepted, encoded as NOP 0x00000013, and set err. Illegal requests are alu_ctrl 100, 110 or 111, and sub with imm_sel=1. The last flag is kept.
- States:
  - IDLE: FIFO empty, not done.
  - WRITE: FIFO non-empty.
  - DONE: entered after a commit of an entry with last=1, or a commit at address 2^ADDR_W-1.
- DONE is left only by rst_n or clear. Entries remaining in the FIFO on entering DONE are discarded.
- The address increments by 1 per commit and never wraps.

## Timing
- Reset values: req_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0. Asynchronous reset asserts these immediately, including mid-burst.
- req_ready = !full && !done, with no combinational path from req_valid.
- imem_we = !empty && !done, with imem_wdata and imem_addr registered and stable while imem_we && !imem_ready.
- Latency: a request accepted at edge N is presented with imem_we=1 in the cycle after edge N.
- Throughput: 1 word/cycle with imem_ready held high.
- Push and pop on the same edge are both allowed. When full, push is blocked by req_ready=0.
- done rises in the cycle after the terminating commit. imem_we is 0 from that cycle.
- clear has priority over a simultaneous push or commit.

## Structure
- Shared package riscv_pkg holds:
  - ALU_ADD/SUB/SLT/OR/AND codes.
  - OP_RTYPE, OP_ITYPE.
  - F3_* and F7_SUB constants.
  - NOP_INSN.
- The decoder and this block share riscv_pkg.
- One sub-module, enc_fifo: a synchronous FIFO, 33 bits wide, FIFO_DEPTH deep, with full/empty outputs.
- The encoder mux and FSM live in the top level.

## Test plan
- add R rd=1 rs1=2 rs2=3, imem_ready=1: the word 0x003100B3 is written at addr 0 one cycle after acceptance.
- sub R rd=5 rs1=6 rs2=7, then and I rd=1 rs1=1 imm=0xFFF: 0x407302B3 at addr 0 and 0xFFF0F093 at addr 1 on consecutive cycles.
- sub with imm_sel=1, or alu_ctrl=110: 0x00000013 is written and err=1 stays set until clear.
- imem_ready=0 with 5 requests offered: 4 are accepted, then req_ready=0 and address/data stay stable. After imem_ready=1, 4 commits occur at addrs 0..3 and req_ready returns to 1.
- ADDR_W=2, 6 back-to-back requests: after the commit at addr 3, done=1, req_ready=0 and imem_we=0. A second run with req_last on the 2nd request gives done after addr 1.
- rst_n low mid-burst: all outputs take their reset values asynchronously, and the next accepted request is written at addr 0. clear gives the same result synchronously.
